// File: rtl/sram_req_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_req_ctrl_if
//   Bundles the core-side request/response handshake and the SRAM pin group
//   of sram_req_ctrl. Signal names keep the original _i/_o suffixes as seen
//   from the controller.
//
//   slave  modport : the controller (sram_req_ctrl)
//   master modport : the core plus SRAM macro side (drives requests, consumes
//                    responses, returns sram_rdata_i)
//
//   req_valid_i/req_ready_o   : request handshake
//   req_addr_i/we_i/size_i/wdata_i : byte address, store flag, size, LSB data
//   rsp_valid_o/rsp_ready_i   : response handshake
//   rsp_rdata_o/rsp_err_o     : load data (LSB aligned) and error flag
//   sram_csb_o/we_o           : active-low chip select / write enable
//   sram_addr_o/wdata_o/wmask_o : word address, lane data, byte mask
//   sram_rdata_i              : read data returned by the SRAM
// -----------------------------------------------------------------------------
interface sram_req_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_wdata_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  logic        sram_csb_o;
  logic        sram_we_o;
  logic [12:0] sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [3:0]  sram_wmask_o;
  logic [31:0] sram_rdata_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_size_i, req_wdata_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  rsp_ready_i,
    output sram_csb_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_wmask_o,
    input  sram_rdata_i
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_size_i, req_wdata_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output rsp_ready_i,
    input  sram_csb_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_wmask_o,
    output sram_rdata_i
  );
endinterface

// File: rtl/sram_req_ctrl.sv
// -----------------------------------------------------------------------------
// sram_req_ctrl
//   Request front-end for sram_top. Accepts byte-addressed loads/stores over a
//   valid/ready handshake, issues registered SRAM word accesses (chip select,
//   active-low write enable, byte mask, lane-shifted write data), follows the
//   fixed SRAM read latency with a token pipeline, and returns one response
//   per accepted request, in order, through a backpressured response FIFO.
//
// Parameters
//   RD_LATENCY : cycles from the SRAM sampling a read to valid sram_rdata_i (>=1)
//   RSP_DEPTH  : response FIFO entries (>= RD_LATENCY+2 for full throughput)
//
// Ports
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : sram_req_ctrl_if.slave (request, response and SRAM pin groups)
//
// Optional feature
//   SRAM_REQ_CTRL_MISALIGN_ERR_EN : when defined, size 3 and misaligned
//   half/word requests are accepted but not issued, and answer with
//   rsp_err_o=1, rsp_rdata_o=0. When undefined, rsp_err_o is tied low, size 3
//   behaves as a word and misaligned masks are truncated at the word edge.
// -----------------------------------------------------------------------------
module sram_req_ctrl #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sram_req_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef struct packed {
    logic       is_load;
    logic [1:0] off;
    size_e      size;
    logic       err;
  } token_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  localparam int unsigned NSTG = RD_LATENCY + 1;
  localparam int unsigned PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW   = $clog2(RSP_DEPTH + 1);
  localparam int unsigned SW   = $clog2(RSP_DEPTH + NSTG + 1);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  size_e       w_size;
  logic [1:0]  w_off;
  logic        w_err;
  logic [3:0]  w_base_mask;
  logic [3:0]  w_lane_mask;
  logic [31:0] w_lane_wdata;
  logic        w_req_ready;
  logic        w_accept;
  token_t      w_tok_in;

  assign w_size = size_e'(bus.req_size_i);
  assign w_off  = bus.req_addr_i[1:0];

`ifdef SRAM_REQ_CTRL_MISALIGN_ERR_EN
  assign w_err = (w_size == SZ_RSVD) ||
                 ((w_size == SZ_HALF) && w_off[0]) ||
                 ((w_size == SZ_WORD) && (w_off != 2'b00));
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    w_base_mask = 4'hF;
    unique case (w_size)
      SZ_BYTE: w_base_mask = 4'h1;
      SZ_HALF: w_base_mask = 4'h3;
      default: w_base_mask = 4'hF;  // word, and reserved size treated as word
    endcase
    // 4-bit shift drops lanes past byte 3; no wrap into the next word
    w_lane_mask = w_base_mask << w_off;
  end

  assign w_lane_wdata = bus.req_wdata_i << {w_off, 3'b000};

  always_comb begin
    w_tok_in         = '0;
    w_tok_in.is_load = !bus.req_we_i;
    w_tok_in.off     = w_off;
    w_tok_in.size    = w_size;
    w_tok_in.err     = w_err;
  end

  // ---------------------------------------------------------------------------
  // Credit accounting
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_cnt;
  logic [NSTG-1:0] r_tok_vld;
  logic [SW-1:0] w_inflight;
  logic [SW-1:0] w_credit_used;

  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < NSTG; i++) begin
      w_inflight = w_inflight + SW'(r_tok_vld[i]);
    end
  end

  // Uses the FIFO count at the start of the cycle: a same-cycle pop frees its
  // credit only on the next cycle, which keeps ready off the pop path.
  assign w_credit_used = SW'(r_cnt) + w_inflight;
  assign w_req_ready   = !rst_i && (w_credit_used < SW'(RSP_DEPTH));
  assign w_accept      = bus.req_valid_i && w_req_ready;
  assign bus.req_ready_o = w_req_ready;

  // ---------------------------------------------------------------------------
  // SRAM issue registers
  // ---------------------------------------------------------------------------
  logic        r_csb;
  logic        r_we_n;
  logic [12:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_csb   <= 1'b1;
      r_we_n  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_accept && !w_err) begin
      r_csb   <= 1'b0;
      r_we_n  <= !bus.req_we_i;
      r_addr  <= bus.req_addr_i[14:2];
      r_wdata <= w_lane_wdata;
      r_wmask <= bus.req_we_i ? w_lane_mask : 4'h0;
    end else begin
      // Idle or error request: deselect, keep the data pins as they were
      r_csb  <= 1'b1;
      r_we_n <= 1'b1;
    end
  end

  assign bus.sram_csb_o   = r_csb;
  assign bus.sram_we_o    = r_we_n;
  assign bus.sram_addr_o  = r_addr;
  assign bus.sram_wdata_o = r_wdata;
  assign bus.sram_wmask_o = r_wmask;

  // ---------------------------------------------------------------------------
  // Token pipeline: stage NSTG-1 lines up with valid sram_rdata_i
  // ---------------------------------------------------------------------------
  token_t r_tok [NSTG];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tok_vld <= '0;
      for (int unsigned i = 0; i < NSTG; i++) begin
        r_tok[i] <= '0;
      end
    end else begin
      r_tok_vld[0] <= w_accept;
      r_tok[0]     <= w_tok_in;
      for (int unsigned i = 1; i < NSTG; i++) begin
        r_tok_vld[i] <= r_tok_vld[i-1];
        r_tok[i]     <= r_tok[i-1];
      end
    end
  end

  token_t      w_last;
  logic [31:0] w_shift;
  rsp_t        w_rsp;

  assign w_last  = r_tok[NSTG-1];
  assign w_shift = bus.sram_rdata_i >> {w_last.off, 3'b000};

  always_comb begin
    w_rsp       = '0;
    w_rsp.err   = w_last.err;
    w_rsp.rdata = '0;
    if (w_last.is_load && !w_last.err) begin
      unique case (w_last.size)
        SZ_BYTE: w_rsp.rdata = {24'h0, w_shift[7:0]};
        SZ_HALF: w_rsp.rdata = {16'h0, w_shift[15:0]};
        default: w_rsp.rdata = w_shift;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  rsp_t          r_fifo [RSP_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          w_push;
  logic          w_pop;
  logic          w_rsp_valid;
  rsp_t          w_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_rsp_valid = (r_cnt != '0);
  assign w_push      = r_tok_vld[NSTG-1];
  assign w_pop       = w_rsp_valid && bus.rsp_ready_i;
  assign w_head      = r_fifo[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wptr] <= w_rsp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Entry storage is not reset, so the data outputs are gated by valid
  assign bus.rsp_valid_o = w_rsp_valid;
  assign bus.rsp_rdata_o = w_rsp_valid ? w_head.rdata : '0;
`ifdef SRAM_REQ_CTRL_MISALIGN_ERR_EN
  assign bus.rsp_err_o   = w_rsp_valid && w_head.err;
`else
  assign bus.rsp_err_o   = 1'b0;
`endif

  // Address bits above the SRAM window are ignored by design
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, bus.req_addr_i[31:15], w_head.err};

endmodule

// File: tb/tb_sram_req_ctrl.sv
module tb_sram_req_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_req_ctrl_if bus ();

  sram_req_ctrl #(.RD_LATENCY(1), .RSP_DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Behavioural SRAM: one-cycle read latency, masked byte writes
  logic [31:0] mem [0:8191];
  logic [31:0] sram_rd = '0;
  always @(posedge clk) begin
    if (!bus.sram_csb_o) begin
      if (!bus.sram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_wmask_o[b]) mem[bus.sram_addr_o][8*b +: 8] <= bus.sram_wdata_o[8*b +: 8];
      end else begin
        sram_rd <= mem[bus.sram_addr_o];
      end
    end
  end
  assign bus.sram_rdata_i = sram_rd;

  // Response monitor
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } rsp_rec_t;
  rsp_rec_t rq[$];

  always @(posedge clk)
    if (bus.rsp_valid_o && bus.rsp_ready_i) rq.push_back('{bus.rsp_err_o, bus.rsp_rdata_o, cyc});

  // Drive one request, wait (bounded) for acceptance; returns at edge+1
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, output int acc, output bit ok);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_size_i  = size;
    bus.req_wdata_i = wdata;
    ok  = 1'b0;
    acc = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      if (bus.req_ready_o) begin ok = 1'b1; acc = cyc; end
    end
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (rq.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready_o); end
    n_checks++; if (bus.sram_csb_o !== 1'b1) begin n_fail++; $display("FAIL reset_csb: got %b expected 1", bus.sram_csb_o); end
    n_checks++; if (bus.sram_we_o !== 1'b1) begin n_fail++; $display("FAIL reset_we: got %b expected 1", bus.sram_we_o); end
    n_checks++; if (bus.sram_addr_o !== 13'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.sram_addr_o); end
    n_checks++; if (bus.sram_wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", bus.sram_wdata_o); end
    n_checks++; if (bus.sram_wmask_o !== 4'h0) begin n_fail++; $display("FAIL reset_wmask: got %h expected 0", bus.sram_wmask_o); end
    n_checks++; if (bus.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid_o); end
    n_checks++; if (bus.rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 0", bus.rsp_rdata_o); end
    n_checks++; if (bus.rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err_o); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_word_store_load;
    int acc; bit ok; rsp_rec_t r;
    rq.delete();
    do_req(1'b1, 32'h10, 2'd2, 32'hDEADBEEF, acc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wst_accept: got timeout expected accept"); end
    n_checks++; if (bus.sram_csb_o !== 1'b0) begin n_fail++; $display("FAIL wst_csb: got %b expected 0", bus.sram_csb_o); end
    n_checks++; if (bus.sram_we_o !== 1'b0) begin n_fail++; $display("FAIL wst_we: got %b expected 0", bus.sram_we_o); end
    n_checks++; if (bus.sram_addr_o !== 13'd4) begin n_fail++; $display("FAIL wst_addr: got %h expected 4", bus.sram_addr_o); end
    n_checks++; if (bus.sram_wmask_o !== 4'hF) begin n_fail++; $display("FAIL wst_wmask: got %h expected f", bus.sram_wmask_o); end
    n_checks++; if (bus.sram_wdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wst_wdata: got %h expected deadbeef", bus.sram_wdata_o); end
    wait_rsp(1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wst_rsp: got timeout expected response"); end
    if (ok) begin
      r = rq.pop_front();
      n_checks++; if (r.rdata !== 32'h0 || r.err !== 1'b0) begin n_fail++; $display("FAIL wst_rsp_data: got %h/%b expected 0/0", r.rdata, r.err); end
      n_checks++; if (r.cyc - acc !== 3) begin n_fail++; $display("FAIL wst_latency: got %0d expected 3", r.cyc - acc); end
    end
    do_req(1'b0, 32'h10, 2'd2, 32'h0, acc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wld_accept: got timeout expected accept"); end
    n_checks++; if (bus.sram_csb_o !== 1'b0 || bus.sram_we_o !== 1'b1) begin n_fail++; $display("FAIL wld_ctl: got csb=%b we=%b expected csb=0 we=1", bus.sram_csb_o, bus.sram_we_o); end
    n_checks++; if (bus.sram_wmask_o !== 4'h0) begin n_fail++; $display("FAIL wld_wmask: got %h expected 0", bus.sram_wmask_o); end
    wait_rsp(1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wld_rsp: got timeout expected response"); end
    if (ok) begin
      r = rq.pop_front();
      n_checks++; if (r.rdata !== 32'hDEADBEEF || r.err !== 1'b0) begin n_fail++; $display("FAIL wld_rdata: got %h/%b expected deadbeef/0", r.rdata, r.err); end
      n_checks++; if (r.cyc - acc !== 3) begin n_fail++; $display("FAIL wld_latency: got %0d expected 3", r.cyc - acc); end
    end
  endtask

  task automatic test_byte_access;
    int acc; bit ok; rsp_rec_t r;
    rq.delete();
    do_req(1'b1, 32'h13, 2'd0, 32'h000000AB, acc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bst_accept: got timeout expected accept"); end
    n_checks++; if (bus.sram_wmask_o !== 4'h8) begin n_fail++; $display("FAIL bst_wmask: got %h expected 8", bus.sram_wmask_o); end
    n_checks++; if (bus.sram_wdata_o !== 32'hAB000000) begin n_fail++; $display("FAIL bst_wdata: got %h expected ab000000", bus.sram_wdata_o); end
    do_req(1'b0, 32'h13, 2'd0, 32'h0, acc, ok);
    do_req(1'b0, 32'h10, 2'd2, 32'h0, acc, ok);
    wait_rsp(3, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL byte_rsp: got %0d responses expected 3", rq.size()); end
    if (ok) begin
      r = rq.pop_front();
      n_checks++; if (r.rdata !== 32'h0) begin n_fail++; $display("FAIL bst_rsp: got %h expected 0", r.rdata); end
      r = rq.pop_front();
      n_checks++; if (r.rdata !== 32'h000000AB) begin n_fail++; $display("FAIL bld_rdata: got %h expected 000000ab", r.rdata); end
      r = rq.pop_front();
      n_checks++; if (r.rdata !== 32'hABADBEEF) begin n_fail++; $display("FAIL bwld_rdata: got %h expected abadbeef", r.rdata); end
    end
  endtask

  task automatic test_back_to_back;
    int k; int first; int last; bit ok; rsp_rec_t r;
    rq.delete();
    bus.rsp_ready_i = 1'b1;
    k = 0; first = -1; last = -1;
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'd2;
    bus.req_addr_i = 32'h100; bus.req_wdata_i = 32'hC0DE0000;
    for (int c = 0; c < 40 && k < 8; c++) begin
      @(posedge clk);
      if (bus.req_ready_o) begin if (k == 0) first = cyc; last = cyc; k++; end
      #1;
      bus.req_addr_i  = 32'h100 + 32'(4 * k);
      bus.req_wdata_i = 32'hC0DE0000 | 32'(k);
    end
    bus.req_valid_i = 1'b0;
    n_checks++; if (last - first !== 7) begin n_fail++; $display("FAIL b2b_store_rate: got span %0d expected 7", last - first); end
    wait_rsp(8, ok);
    n_checks++; if (rq.size() !== 8) begin n_fail++; $display("FAIL b2b_store_rsp: got %0d expected 8", rq.size()); end
    rq.delete();

    bus.rsp_ready_i = 1'b0;
    k = 0;
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_addr_i = 32'h100;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      if (bus.req_ready_o) k++;
      #1 bus.req_addr_i = 32'h100 + 32'(4 * k);
    end
    @(negedge clk);
    n_checks++; if (k !== 4) begin n_fail++; $display("FAIL b2b_stall_accepts: got %0d expected 4", k); end
    n_checks++; if (bus.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_ready: got %b expected 0", bus.req_ready_o); end
    n_checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== 32'hC0DE0000) begin n_fail++; $display("FAIL b2b_stall_head: got %b/%h expected 1/c0de0000", bus.rsp_valid_o, bus.rsp_rdata_o); end
    bus.rsp_ready_i = 1'b1;
    for (int c = 0; c < 60 && k < 8; c++) begin
      @(posedge clk);
      if (bus.req_ready_o) k++;
      #1 bus.req_addr_i = 32'h100 + 32'(4 * k);
    end
    bus.req_valid_i = 1'b0;
    wait_rsp(8, ok);
    n_checks++; if (rq.size() !== 8) begin n_fail++; $display("FAIL b2b_load_count: got %0d expected 8", rq.size()); end
    for (int i = 0; i < 8 && rq.size() > 0; i++) begin
      r = rq.pop_front();
      n_checks++; if (r.rdata !== (32'hC0DE0000 | 32'(i)) || r.err !== 1'b0) begin n_fail++; $display("FAIL b2b_load_%0d: got %h/%b expected %h/0", i, r.rdata, r.err, 32'hC0DE0000 | 32'(i)); end
    end
  endtask

  task automatic test_misalign;
    int acc; bit ok; rsp_rec_t r;
    rq.delete();
    do_req(1'b0, 32'h10, 2'd2, 32'h0, acc, ok);
    do_req(1'b0, 32'h11, 2'd1, 32'h0, acc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mis_accept: got timeout expected accept"); end
`ifdef SRAM_REQ_CTRL_MISALIGN_ERR_EN
    n_checks++; if (bus.sram_csb_o !== 1'b1) begin n_fail++; $display("FAIL mis_csb: got %b expected 1", bus.sram_csb_o); end
`else
    n_checks++; if (bus.sram_csb_o !== 1'b0 || bus.sram_addr_o !== 13'd4) begin n_fail++; $display("FAIL mis_issue: got csb=%b addr=%h expected 0/4", bus.sram_csb_o, bus.sram_addr_o); end
`endif
    wait_rsp(2, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mis_rsp: got %0d responses expected 2", rq.size()); end
    if (ok) begin
      r = rq.pop_front();
      n_checks++; if (r.rdata !== 32'hABADBEEF || r.err !== 1'b0) begin n_fail++; $display("FAIL mis_prev: got %h/%b expected abadbeef/0", r.rdata, r.err); end
      r = rq.pop_front();
`ifdef SRAM_REQ_CTRL_MISALIGN_ERR_EN
      n_checks++; if (r.rdata !== 32'h0 || r.err !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %h/%b expected 0/1", r.rdata, r.err); end
`else
      n_checks++; if (r.rdata !== 32'h0000ADBE || r.err !== 1'b0) begin n_fail++; $display("FAIL mis_half: got %h/%b expected 0000adbe/0", r.rdata, r.err); end
`endif
      n_checks++; if (r.cyc - acc !== 3) begin n_fail++; $display("FAIL mis_latency: got %0d expected 3", r.cyc - acc); end
    end
  endtask

  task automatic test_reset_mid;
    int acc; bit ok;
    rq.delete();
    do_req(1'b0, 32'h10, 2'd2, 32'h0, acc, ok);
    do_req(1'b0, 32'h100, 2'd2, 32'h0, acc, ok);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_in_rst: got %b expected 0", bus.req_ready_o); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.sram_csb_o !== 1'b1 || bus.sram_we_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ctl: got csb=%b we=%b expected 1/1", bus.sram_csb_o, bus.sram_we_o); end
    n_checks++; if (bus.sram_addr_o !== 13'h0 || bus.sram_wdata_o !== 32'h0 || bus.sram_wmask_o !== 4'h0) begin n_fail++; $display("FAIL rmid_pins: got %h/%h/%h expected 0/0/0", bus.sram_addr_o, bus.sram_wdata_o, bus.sram_wmask_o); end
    n_checks++; if (bus.rsp_valid_o !== 1'b0 || bus.rsp_rdata_o !== 32'h0 || bus.rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp: got %b/%h/%b expected 0/0/0", bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_err_o); end
    n_checks++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", bus.req_ready_o); end
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (rq.size() !== 0) begin n_fail++; $display("FAIL rmid_no_rsp: got %0d expected 0", rq.size()); end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_size_i  = '0;
    bus.req_wdata_i = '0;
    bus.rsp_ready_i = 1'b1;
    test_reset();
    test_word_store_load();
    test_byte_access();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

endmodule
